// File: rtl/display_color_encoder_lut.sv
// display_color_encoder_lut
//   Maps every colour channel of SEGMENTS pixels through a per-channel,
//   run-time writable lookup table (BITWIDTH in -> CYCLEWIDTH PWM cycles out),
//   then applies a global brightness scale. Two-stage valid/ready pipeline:
//   stage 1 = LUT lookup, stage 2 = brightness scale.
//
//   Optional feature: define DISPLAY_COLOR_BRIGHTNESS_EN to enable the
//   brightness multiply. Without it stage 2 passes the LUT value through,
//   the brightness port is ignored and the latency is unchanged.
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset (pipeline control and cpixel)
//   pixel       input lanes, lane L at [L*BITWIDTH +: BITWIDTH], L = s*CHANNELS+c
//   in_valid    pixel valid            in_ready   encoder can accept
//   cpixel      output lanes, lane L at [L*CYCLEWIDTH +: CYCLEWIDTH]
//   out_valid   cpixel valid           out_ready  consumer accepts cpixel
//   lut_we/lut_chan/lut_addr/lut_data  LUT write port (always active)
//   brightness  global brightness, 255 = unity
module display_color_encoder_lut #(
  parameter int SEGMENTS   = 1,
  parameter int BITWIDTH   = 8,
  parameter int CYCLEWIDTH = 10,
  parameter int CHANNELS   = 3
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [BITWIDTH*CHANNELS*SEGMENTS-1:0]    pixel,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  output logic [CYCLEWIDTH*CHANNELS*SEGMENTS-1:0]  cpixel,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  input  logic                                     lut_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] lut_chan,
  input  logic [BITWIDTH-1:0]                      lut_addr,
  input  logic [CYCLEWIDTH-1:0]                    lut_data,
  input  logic [7:0]                               brightness
);

  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int LANES  = CHANNELS * SEGMENTS;
  localparam int DEPTH  = 2 ** BITWIDTH;
  localparam int MEM_W  = CHANNELS * DEPTH * CYCLEWIDTH;
  localparam logic [CHAN_W:0] CHAN_LIM = (CHAN_W + 1)'(CHANNELS);

  // Linear power-up map: entry n holds n left-aligned in CYCLEWIDTH bits.
  function automatic logic [MEM_W-1:0] lut_init();
    logic [MEM_W-1:0] m;
    m = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int n = 0; n < DEPTH; n++) begin
        m[(c * DEPTH + n) * CYCLEWIDTH +: CYCLEWIDTH] =
          CYCLEWIDTH'(n) << (CYCLEWIDTH - BITWIDTH);
      end
    end
    return m;
  endfunction

`ifdef DISPLAY_COLOR_BRIGHTNESS_EN
  // (v * (b + 1)) >> 8; never exceeds v, so the truncation is lossless.
  function automatic logic [CYCLEWIDTH-1:0] scale_lane(
    input logic [CYCLEWIDTH-1:0] v,
    input logic [7:0]            b
  );
    logic [CYCLEWIDTH+8:0] prod;
    prod = (CYCLEWIDTH + 9)'(v) * (CYCLEWIDTH + 9)'({1'b0, b} + 9'd1);
    return prod[CYCLEWIDTH+7:8];
  endfunction
`endif

  // All channel tables packed into one vector so the power-up contents can
  // be given as a declaration initialiser. Reset never touches it.
  logic [MEM_W-1:0]            lut_mem = lut_init();
  logic                        lut_wr_ok;
  logic                        adv;
  logic [LANES*CYCLEWIDTH-1:0] lut_rd;
  logic [LANES*CYCLEWIDTH-1:0] scaled;
  logic                        vld_p1;
  logic [LANES*CYCLEWIDTH-1:0] lut_p1;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign lut_wr_ok = lut_we && ({1'b0, lut_chan} < CHAN_LIM);

  // Write lands at the clock edge, so a lookup in the same cycle still sees
  // the old entry.
  always @(posedge clk) begin
    if (lut_wr_ok) begin
      lut_mem[(int'(lut_chan) * DEPTH + int'(lut_addr)) * CYCLEWIDTH +: CYCLEWIDTH] <= lut_data;
    end
  end

  always_comb begin
    lut_rd = '0;
    for (int l = 0; l < LANES; l++) begin
      lut_rd[l * CYCLEWIDTH +: CYCLEWIDTH] =
        lut_mem[((l % CHANNELS) * DEPTH + int'(pixel[l * BITWIDTH +: BITWIDTH])) * CYCLEWIDTH
                +: CYCLEWIDTH];
    end
  end

  // Stage 1 boundary: LUT value registered
  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      lut_p1 <= lut_rd;
    end
  end

  always_comb begin
    scaled = '0;
    for (int l = 0; l < LANES; l++) begin
`ifdef DISPLAY_COLOR_BRIGHTNESS_EN
      scaled[l * CYCLEWIDTH +: CYCLEWIDTH] =
        scale_lane(lut_p1[l * CYCLEWIDTH +: CYCLEWIDTH], brightness);
`else
      scaled[l * CYCLEWIDTH +: CYCLEWIDTH] = lut_p1[l * CYCLEWIDTH +: CYCLEWIDTH];
`endif
    end
  end

`ifndef DISPLAY_COLOR_BRIGHTNESS_EN
  logic unused_brightness;
  assign unused_brightness = ^brightness;
`endif

  // Stage 2 boundary: scaled value drives cpixel; everything holds when adv=0
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      cpixel    <= '0;
    end else if (adv) begin
      vld_p1    <= in_valid;
      out_valid <= vld_p1;
      if (vld_p1) begin
        cpixel <= scaled;
      end
    end
  end

endmodule

// File: tb/tb_display_color_encoder_lut.sv
module tb_display_color_encoder_lut;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] pixel;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] cpixel;
  logic        out_valid;
  logic        out_ready;
  logic        lut_we;
  logic [1:0]  lut_chan;
  logic [7:0]  lut_addr;
  logic [9:0]  lut_data;
  logic [7:0]  brightness;

  int n_chk  = 0;
  int n_pass = 0;

  display_color_encoder_lut #(
    .SEGMENTS(1), .BITWIDTH(8), .CYCLEWIDTH(10), .CHANNELS(3)
  ) dut (
    .clk(clk), .rst(rst), .pixel(pixel), .in_valid(in_valid), .in_ready(in_ready),
    .cpixel(cpixel), .out_valid(out_valid), .out_ready(out_ready),
    .lut_we(lut_we), .lut_chan(lut_chan), .lut_addr(lut_addr), .lut_data(lut_data),
    .brightness(brightness)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic lut_write(input logic [1:0] ch, input logic [7:0] a, input logic [9:0] d);
    @(negedge clk);
    lut_we = 1'b1; lut_chan = ch; lut_addr = a; lut_data = d;
    @(negedge clk);
    lut_we = 1'b0;
  endtask

  // One pixel through an idle pipeline: out_valid exactly two edges later.
  task automatic run_pixel(input string tag, input logic [23:0] pix, input logic [29:0] exp);
    @(negedge clk);
    pixel = pix; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat1"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_vld"}, out_valid, 1);
    check(tag, cpixel, exp);
    @(negedge clk);
    check({tag, "_drain"}, out_valid, 0);
  endtask

  logic [23:0] spix [8];
  logic [29:0] sexp [8];

  initial begin
    logic [7:0]  l0, l1, l2;
    logic [9:0]  e0, e1, e2;
    logic [29:0] hold;
    int ii, oi;

    rst = 1'b1; pixel = '0; in_valid = 1'b0; out_ready = 1'b1;
    lut_we = 1'b0; lut_chan = '0; lut_addr = '0; lut_data = '0; brightness = 8'd255;
    hold = '0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_cpixel", cpixel, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // Identity LUT, unity brightness
    run_pixel("identity", 24'h012080, {10'h004, 10'h080, 10'h200});

    // Channel-1 entry rewritten; other channels stay linear
    lut_write(2'd1, 8'h10, 10'h3FF);
    run_pixel("lut_ch1", 24'h101010, {10'h040, 10'h3FF, 10'h040});

    // Out-of-range channel write is dropped
    lut_write(2'd3, 8'h10, 10'h155);
    run_pixel("bad_chan", 24'h101010, {10'h040, 10'h3FF, 10'h040});

    // Same-cycle write and lookup: old value, then new value
    @(negedge clk);
    lut_we = 1'b1; lut_chan = 2'd0; lut_addr = 8'h22; lut_data = 10'h111;
    pixel = 24'h000022; in_valid = 1'b1;
    @(negedge clk);
    lut_we = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("wr_rd_old_vld", out_valid, 1);
    check("wr_rd_old", cpixel, 30'h088);
    @(negedge clk);
    check("wr_rd_new_vld", out_valid, 1);
    check("wr_rd_new", cpixel, 30'h111);
    @(negedge clk);
    check("wr_rd_drain", out_valid, 0);

    // Brightness scaling
    lut_write(2'd2, 8'hFF, 10'h3FF);
    brightness = 8'd127;
`ifdef DISPLAY_COLOR_BRIGHTNESS_EN
    run_pixel("bright127", 24'hFF0080, {10'h1FF, 10'h000, 10'h100});
`else
    run_pixel("bright127", 24'hFF0080, {10'h3FF, 10'h000, 10'h200});
`endif
    brightness = 8'd0;
`ifdef DISPLAY_COLOR_BRIGHTNESS_EN
    run_pixel("bright0", 24'hFF0080, {10'h003, 10'h000, 10'h002});
`else
    run_pixel("bright0", 24'hFF0080, {10'h3FF, 10'h000, 10'h200});
`endif
    brightness = 8'd255;

    // Streaming with a three-cycle output stall
    for (int i = 0; i < 8; i++) begin
      l0 = 8'(8'h30 + 3 * i); l1 = 8'(8'h50 + i); l2 = 8'(8'hA0 + i);
      e0 = 10'(l0) << 2; e1 = 10'(l1) << 2; e2 = 10'(l2) << 2;
      spix[i] = {l2, l1, l0};
      sexp[i] = {e2, e1, e0};
    end
    ii = 0; oi = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      out_ready = !(k >= 3 && k <= 5);
      in_valid  = (ii < 8);
      pixel     = (ii < 8) ? spix[ii] : 24'h0;
      #1;
      if (k >= 3 && k <= 5) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
      end
      if (k == 3) hold = cpixel;
      if (k == 4 || k == 5) check("stall_hold", cpixel, hold);
      if (out_valid && out_ready) begin
        if (oi < 8) check("stream_out", cpixel, sexp[oi]);
        oi++;
      end
      if (in_valid && in_ready) ii++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream_in_count", ii, 8);
    check("stream_out_count", oi, 8);

    // Reset with two pixels in flight; LUT write during reset still lands
    @(negedge clk);
    pixel = 24'h000033; in_valid = 1'b1;
    @(negedge clk);
    pixel = 24'h000044; out_ready = 1'b0;
    @(negedge clk);
    check("flight_pre_vld", out_valid, 1);
    in_valid = 1'b0; rst = 1'b1;
    lut_we = 1'b1; lut_chan = 2'd0; lut_addr = 8'h05; lut_data = 10'h2AA;
    @(negedge clk);
    rst = 1'b0; lut_we = 1'b0; out_ready = 1'b1;
    check("flight_rst_vld", out_valid, 0);
    check("flight_rst_cpixel", cpixel, 0);
    check("flight_rst_in_ready", in_ready, 1);
    repeat (3) begin
      @(negedge clk);
      check("flight_discard", out_valid, 0);
    end
    run_pixel("lut_kept", 24'hFF1005, {10'h3FF, 10'h3FF, 10'h2AA});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/display_color_encoder_lut.md
DISPLAY_COLOR_ENCODER_LUT -- requirements
Module: display_color_encoder_lut

Interface
REQ-001 SHALL have parameter SEGMENTS, default 1, number of pixels encoded in parallel.
REQ-002 SHALL have parameter BITWIDTH, default 8, input bits per colour channel.
REQ-003 SHALL have parameter CYCLEWIDTH, default 10, output PWM-cycle bits per channel; CYCLEWIDTH >= BITWIDTH.
REQ-004 SHALL have parameter CHANNELS, default 3, colour channels per pixel; channel c of segment s at lane index s*CHANNELS+c.
REQ-005 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 pixel  in  BITWIDTH*CHANNELS*SEGMENTS  input pixels, lane L at bits [L*BITWIDTH +: BITWIDTH].
REQ-008 in_valid  in  1  pixel valid; in_ready  out  1  encoder accepts pixel this cycle.
REQ-009 cpixel  out  CYCLEWIDTH*CHANNELS*SEGMENTS  encoded pixels, lane L at [L*CYCLEWIDTH +: CYCLEWIDTH].
REQ-010 out_valid  out  1  cpixel valid; out_ready  in  1  consumer accepts cpixel.
REQ-011 lut_we  in  1  LUT write strobe; lut_chan  in  clog2(CHANNELS)  target channel; lut_addr  in  BITWIDTH  entry; lut_data  in  CYCLEWIDTH  value.
REQ-012 brightness  in  8  global brightness, 255 = unity.

Function
REQ-013 SHALL hold one LUT of 2**BITWIDTH x CYCLEWIDTH per channel, shared by all segments of that channel.
REQ-014 SHALL power up each LUT as linear map: entry n = {n, (CYCLEWIDTH-BITWIDTH) zero bits}.
REQ-015 SHALL write lut_data to LUT[lut_chan][lut_addr] on any cycle with lut_we=1, independent of handshake state.
REQ-016 lut_we with lut_chan >= CHANNELS SHALL be ignored.
REQ-017 Same-cycle lookup and write of one entry SHALL return pre-write value; lookups on later cycles SHALL return new value.
REQ-018 SHALL be a 2-stage pipeline: S1 = LUT lookup, S2 = brightness scale; fixed latency 2 cycles from accept to out_valid with no stall.
REQ-019 Pipeline advance signal SHALL be adv = !out_valid || out_ready; in_ready = adv (combinational).
REQ-020 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-021 When adv=0 both stages, cpixel and out_valid SHALL hold unchanged; pixel, in_valid ignored.
REQ-022 Stage valid bits SHALL propagate bubbles; throughput 1 pixel/cycle with out_ready held 1.
REQ-023 S2 output per lane SHALL be (lut_value * (brightness+1)) >> 8, truncated to CYCLEWIDTH; brightness sampled when S1 advances into S2.
REQ-024 brightness=255 SHALL yield exact LUT value; brightness=0 SHALL yield lut_value>>8.
REQ-025 cpixel SHALL not change while out_valid=1 and out_ready=0.

Reset
REQ-026 On rst=1 at a clock edge: out_valid=0, internal stage valids=0, cpixel=0.
REQ-027 in_ready SHALL equal 1 in the cycle after reset.
REQ-028 Reset SHALL NOT alter LUT contents; pixels in flight at reset SHALL be discarded, never emitted.
REQ-029 lut_we asserted during rst=1 SHALL still write.

Configuration
REQ-030 Macro DISPLAY_COLOR_BRIGHTNESS_EN: defined -> REQ-023/024 scaling active.
REQ-031 Undefined -> S2 passes LUT value unchanged, brightness port present but ignored, latency stays 2, no multipliers inferred.

Verification
REQ-032 Reset, identity LUT, brightness=255, pixel lane0=0x80 -> out_valid 2 cycles later, cpixel lane0=0x200.
REQ-033 Write LUT[1][0x10]=0x3FF, send lane1=0x10 -> cpixel lane1=0x3FF; other lanes identity.
REQ-034 Stream 8 pixels, out_ready low cycles 3-5 -> in_ready low while stalled, all 8 outputs in order, none lost/duplicated, cpixel stable during stall.
REQ-035 With macro, LUT=0x3FF, brightness=127 -> cpixel=0x1FF; without macro same stimulus -> 0x3FF.
REQ-036 Write and lookup same entry same cycle -> old value output; next lookup -> new value.
REQ-037 Assert rst with 2 pixels in flight -> out_valid=0 next cycle, neither pixel emitted, LUT writes before reset retained.
